// File: rtl/dmem_arbiter.sv
// Two-way arbiter (CPU MEM stage vs debug/loader) in front of the data-memory/IO port.
// Optional DMEM_ARB_LOCK_EN adds dbg_lock, which makes only the debug port eligible.
module dmem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_LOCK_EN
  ,
  input  logic              dbg_lock
`endif
);

  // state   | meaning
  // IDLE    | nothing on the memory port this cycle
  // CPU_ACC | CPU access on the memory port, cpu_ack high
  // DBG_ACC | debug access on the memory port, dbg_ack high
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    DBG_ACC = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       lock;
  logic       cpu_elig;
  logic       grant_cpu;
  logic       grant_dbg;

`ifdef DMEM_ARB_LOCK_EN
  assign lock = dbg_lock;
`else
  assign lock = 1'b0;
`endif

  // Debug wins when it is the only eligible requester or it has waited out the starve limit.
  assign cpu_elig  = cpu_req & ~lock;
  assign grant_dbg = dbg_req & (~cpu_elig | (starve_cnt == LIMIT));
  assign grant_cpu = cpu_elig & ~grant_dbg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if (grant_dbg) begin
        state     <= DBG_ACC;
        mem_addr  <= dbg_addr;
        mem_wdata <= dbg_wdata;
        mem_we    <= dbg_we;
        mem_re    <= ~dbg_we;
      end else if (grant_cpu) begin
        state     <= CPU_ACC;
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
        mem_we    <= cpu_we;
        mem_re    <= ~cpu_we;
      end else begin
        state  <= IDLE;
        mem_we <= 1'b0;
        mem_re <= 1'b0;
      end

      // A lock freezes the fairness history so the CPU resumes where it left off.
      if (!lock) begin
        if (grant_dbg || !dbg_req)
          starve_cnt <= '0;
        else if (grant_cpu && (starve_cnt != LIMIT))
          starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  assign cpu_ack   = (state == CPU_ACC);
  assign dbg_ack   = (state == DBG_ACC);
  assign cpu_rdata = cpu_ack ? mem_rdata : '0;
  assign dbg_rdata = dbg_ack ? mem_rdata : '0;
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level model plus directed checks; covers dbg_lock
// when DMEM_ARB_LOCK_EN is defined.
module tb_dmem_arbiter;
  localparam int STARVE_LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [15:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ack, cpu_stall, dbg_ack, mem_we, mem_re;
  logic        lock_v;
`ifdef DMEM_ARB_LOCK_EN
  logic        dbg_lock;
  assign lock_v = dbg_lock;
`else
  assign lock_v = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_LOCK_EN
    , .dbg_lock(dbg_lock)
`endif
  );

  always #5 clock = ~clock;

  // Memory seen by the DUT: combinational read, write on the edge where mem_we is high.
  logic [15:0] env_mem [0:255];
  assign mem_rdata = env_mem[mem_addr[7:0]];
  always @(posedge clock) if (mem_we === 1'b1) env_mem[mem_addr[7:0]] <= mem_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the port this cycle, what transaction it carries, and its own memory copy.
  logic [15:0] model_mem [0:255];
  int          exp_owner = 0;          // 0 none, 1 cpu, 2 dbg
  logic [15:0] exp_addr, exp_wdata;
  bit          exp_we = 0, exp_re = 0;
  int          waited = 0;             // CPU wins while debug was pending
  bit          model_valid = 0;

  function automatic int pick(bit c, bit d, int w);
    if (c && d) return (w >= STARVE_LIMIT) ? 2 : 1;
    if (c) return 1;
    if (d) return 2;
    return 0;
  endfunction

  always @(posedge clock) begin
    if (exp_we) model_mem[exp_addr[7:0]] <= exp_wdata;
    model_valid <= 1'b1;
    if (!reset) begin
      exp_owner <= 0; exp_we <= 0; exp_re <= 0;
      exp_addr <= 16'h0; exp_wdata <= 16'h0; waited <= 0;
    end else begin
      case (pick(cpu_req && !lock_v, dbg_req, waited))
        1: begin
          exp_owner <= 1; exp_addr <= cpu_addr; exp_wdata <= cpu_wdata;
          exp_we <= cpu_we; exp_re <= !cpu_we;
          if (!lock_v) waited <= !dbg_req ? 0 : (waited >= STARVE_LIMIT ? STARVE_LIMIT : waited + 1);
        end
        2: begin
          exp_owner <= 2; exp_addr <= dbg_addr; exp_wdata <= dbg_wdata;
          exp_we <= dbg_we; exp_re <= !dbg_we;
          if (!lock_v) waited <= 0;
        end
        default: begin
          exp_owner <= 0; exp_we <= 0; exp_re <= 0;
          if (!lock_v) waited <= 0;
        end
      endcase
    end
  end

  always @(negedge clock) begin
    if (model_valid) begin
      check("cpu_ack", cpu_ack, exp_owner == 1);
      check("dbg_ack", dbg_ack, exp_owner == 2);
      check("cpu_rdata", cpu_rdata, exp_owner == 1 ? model_mem[exp_addr[7:0]] : 16'h0);
      check("dbg_rdata", dbg_rdata, exp_owner == 2 ? model_mem[exp_addr[7:0]] : 16'h0);
      check("cpu_stall", cpu_stall, cpu_req && exp_owner != 1);
      check("mem_we", mem_we, exp_we);
      check("mem_re", mem_re, exp_re);
      check("mem_addr", mem_addr, exp_addr);
      check("mem_wdata", mem_wdata, exp_wdata);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  int pat [10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
  int cpu_n, dbg_n;

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i]   = 16'(i) ^ 16'h5A5A;
      model_mem[i] = 16'(i) ^ 16'h5A5A;
    end
    env_mem[8'h10]   = 16'h1234;
    model_mem[8'h10] = 16'h1234;

    reset = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010; cpu_wdata = 16'h0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 16'h0; dbg_wdata = 16'h0;
`ifdef DMEM_ARB_LOCK_EN
    dbg_lock = 0;
`endif
    step(2);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_re", mem_re, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0);
    check("rst_cpu_ack", cpu_ack, 1'b0);
    check("rst_cpu_stall", cpu_stall, 1'b1);

    reset = 1;
    step(1);
    check("rd_mem_re", mem_re, 1'b1);
    check("rd_mem_addr", mem_addr, 16'h0010);
    check("rd_cpu_ack", cpu_ack, 1'b1);
    check("rd_cpu_rdata", cpu_rdata, 16'h1234);
    check("rd_cpu_stall", cpu_stall, 1'b0);
    cpu_req = 0;

    dbg_req = 1; dbg_we = 1; dbg_addr = 16'h0003; dbg_wdata = 16'h00AA;
    step(1);
    check("wr_mem_we", mem_we, 1'b1);
    check("wr_mem_wdata", mem_wdata, 16'h00AA);
    check("wr_dbg_ack", dbg_ack, 1'b1);
    check("wr_cpu_rdata", cpu_rdata, 16'h0);
    dbg_req = 0;
    step(1);
    check("idle_dbg_ack", dbg_ack, 1'b0);
    check("idle_mem_we", mem_we, 1'b0);
    check("idle_addr_hold", mem_addr, 16'h0003);
    dbg_req = 1; dbg_we = 0;
    step(1);
    check("wr_readback", dbg_rdata, 16'h00AA);
    dbg_req = 0;
    step(1);

    // Contention: both held continuously.
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
    dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0030;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("starve_pattern", {30'h0, dbg_ack, cpu_ack}, 32'(pat[i]));
    end
    cpu_req = 0; dbg_req = 0;
    step(1);

    // Reset sampled at what would have been the grant edge: access dropped.
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0040; cpu_wdata = 16'hBEEF; reset = 0;
    step(1);
    check("mid_rst_cpu_ack", cpu_ack, 1'b0);
    check("mid_rst_mem_we", mem_we, 1'b0);
    reset = 1;
    step(1);
    check("after_rst_cpu_ack", cpu_ack, 1'b1);
    check("after_rst_mem_addr", mem_addr, 16'h0040);
    cpu_req = 0;
    dbg_req = 1; dbg_we = 1; dbg_addr = 16'h0050; dbg_wdata = 16'h7777;
    step(1);
    check("pre_rst_dbg_ack", dbg_ack, 1'b1);
    reset = 0; dbg_req = 0;
    step(1);
    check("rst_drop_dbg_ack", dbg_ack, 1'b0);
    check("rst_drop_mem_addr", mem_addr, 16'h0);
    reset = 1; dbg_req = 1; dbg_we = 0;
    step(1);
    check("rst_edge_write_kept", dbg_rdata, 16'h7777);
    dbg_req = 0; cpu_req = 1; cpu_we = 0;
    step(1);
    check("cpu_write_kept", cpu_rdata, 16'hBEEF);
    cpu_req = 0;

    // Mixed traffic obeying the hold-until-ack handshake.
    for (int i = 0; i < 80; i++) begin
      if (!cpu_req || cpu_ack) begin
        cpu_req = ($urandom_range(0, 3) != 0); cpu_we = $urandom_range(0, 1);
        cpu_addr = 16'($urandom_range(0, 255)); cpu_wdata = 16'($urandom);
      end
      if (!dbg_req || dbg_ack) begin
        dbg_req = ($urandom_range(0, 2) != 0); dbg_we = $urandom_range(0, 1);
        dbg_addr = 16'($urandom_range(0, 255)); dbg_wdata = 16'($urandom);
      end
      step(1);
    end
    cpu_req = 0; dbg_req = 0;
    step(2);

`ifdef DMEM_ARB_LOCK_EN
    dbg_lock = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0011;
    dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0012;
    cpu_n = 0; dbg_n = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("lock_stall", cpu_stall, 1'b1);
      if (cpu_ack) cpu_n++;
      if (dbg_ack) dbg_n++;
    end
    check("lock_dbg_count", dbg_n, 10);
    check("lock_cpu_count", cpu_n, 0);
    dbg_lock = 0; cpu_req = 0; dbg_req = 0;
    step(2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
